// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, datapath
// select encodings, opcode/funct constants and the per-state output decode.
package ctrl_pkg;

  localparam int unsigned STATE_BITS = 7;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH     = 7'h01,
    S_FETCH_WB  = 7'h02,
    S_DECODE    = 7'h03,
    S_EXEC_R    = 7'h04,
    S_R_WB      = 7'h05,
    S_EXEC_I    = 7'h06,
    S_I_WB      = 7'h07,
    S_MEM_ADDR  = 7'h08,
    S_MEM_READ  = 7'h09,
    S_LOAD_WB   = 7'h0A,
    S_MEM_WRITE = 7'h0B,
    S_BRANCH    = 7'h0C,
    S_JUMP      = 7'h0D,
    S_ILLEGAL   = 7'h0E
  } state_t;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;

  localparam logic [2:0] SRCB_REG_B   = 3'b000;
  localparam logic [2:0] SRCB_FOUR    = 3'b001;
  localparam logic [2:0] SRCB_IMM     = 3'b010;
  localparam logic [2:0] SRCB_IMM_SH2 = 3'b011;

  localparam logic [2:0] PCSRC_ALU    = 3'b000;
  localparam logic [2:0] PCSRC_ALUOUT = 3'b001;
  localparam logic [2:0] PCSRC_JUMP   = 3'b010;
  localparam logic [2:0] PCSRC_EXC    = 3'b011;

  localparam logic [1:0] IORD_PC     = 2'b00;
  localparam logic [1:0] IORD_ALUOUT = 2'b01;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;

  typedef struct packed {
    logic [1:0] i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       mem_write;
    logic       reg_write;
    logic       epc_write;
    logic [2:0] pc_source;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    logic [3:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_out_t;

  // R-type ALU operation; ALU_NONE marks an illegal funct.
  function automatic logic [3:0] funct_alu_op(input logic [5:0] funct);
    logic [3:0] op;
    case (funct)
      FN_ADD:  op = ALU_ADD;
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_NONE;
    endcase
    return op;
  endfunction

  // Moore output decode; r_alu_op is only consulted for EXEC_R.
  function automatic ctrl_out_t state_outputs(input state_t s, input logic [3:0] r_alu_op);
    ctrl_out_t o;
    o = '0;
    case (s)
      S_FETCH: begin
        o.i_or_d    = IORD_PC;
        o.alu_src_b = SRCB_FOUR;
        o.alu_op    = ALU_ADD;
      end
      S_FETCH_WB: begin
        o.ir_write  = 1'b1;
        o.pc_write  = 1'b1;
        o.pc_source = PCSRC_ALU;
        o.alu_src_b = SRCB_FOUR;
        o.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        o.alu_src_b = SRCB_IMM_SH2;
        o.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = SRCB_REG_B;
        o.alu_op    = r_alu_op;
      end
      S_R_WB: begin
        o.reg_write = 1'b1;
        o.reg_dst   = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = SRCB_IMM;
        o.alu_op    = ALU_ADD;
      end
      S_I_WB:      o.reg_write = 1'b1;
      S_MEM_READ:  o.i_or_d = IORD_ALUOUT;
      S_LOAD_WB: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        o.i_or_d    = IORD_ALUOUT;
        o.mem_write = 1'b1;
      end
      S_BRANCH: begin
        o.alu_src_a     = 1'b1;
        o.alu_src_b     = SRCB_REG_B;
        o.alu_op        = ALU_SUB;
        o.pc_write_cond = 1'b1;
        o.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o.pc_write  = 1'b1;
        o.pc_source = PCSRC_JUMP;
      end
      S_ILLEGAL: begin
        o.epc_write = 1'b1;
        o.pc_write  = 1'b1;
        o.pc_source = PCSRC_EXC;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Dwell counter for memory-access states: cleared by start, done on the last
// of MEM_WAIT cycles.
module mem_wait_counter #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic done
);

  localparam int unsigned CNT_W = $clog2(MEM_WAIT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || start) count <= '0;
    else                count <= count + CNT_W'(1);
  end

  assign done = (count == CNT_W'(MEM_WAIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control unit for the multicycle MIPS datapath. Outputs are registered
// from the decode of the next state, so they always match the state register.
import ctrl_pkg::*;

module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned STATE_W  = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  output logic [1:0]         i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               mem_write,
  output logic               reg_write,
  output logic               epc_write,
  output logic [2:0]         pc_source,
  output logic               alu_src_a,
  output logic [2:0]         alu_src_b,
  output logic [3:0]         alu_op,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic [STATE_W-1:0] state
);

  state_t    state_q, state_n;
  ctrl_out_t out_q, out_n;
  logic      store_q, store_n;
  logic      start;
  logic      done;

  mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clock (clock),
    .reset (reset),
    .start (start),
    .done  (done)
  );

  // State, decoded lw/sw flag and output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      store_q <= 1'b0;
      out_q   <= state_outputs(S_FETCH, ALU_NONE);
    end else begin
      state_q <= state_n;
      store_q <= store_n;
      out_q   <= out_n;
    end
  end

  // Next state; opcode/funct are only looked at in DECODE.
  always_comb begin
    state_n = state_q;
    store_n = store_q;
    start   = 1'b0;
    case (state_q)
      S_FETCH:    state_n = done ? S_FETCH_WB : S_FETCH;
      S_FETCH_WB: state_n = S_DECODE;
      S_DECODE: begin
        store_n = (opcode == OP_SW);
        case (opcode)
          OP_RTYPE: state_n = (funct_alu_op(funct) != ALU_NONE) ? S_EXEC_R : S_ILLEGAL;
          OP_ADDI:  state_n = S_EXEC_I;
          OP_LW:    state_n = S_MEM_ADDR;
          OP_SW:    state_n = S_MEM_ADDR;
          OP_BEQ:   state_n = S_BRANCH;
          OP_J:     state_n = S_JUMP;
          default:  state_n = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:    state_n = S_R_WB;
      S_EXEC_I:    state_n = S_I_WB;
      S_MEM_ADDR:  state_n = store_q ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_n = done ? S_LOAD_WB : S_MEM_READ;
      S_MEM_WRITE: state_n = done ? S_FETCH : S_MEM_WRITE;
      S_R_WB, S_I_WB, S_LOAD_WB, S_BRANCH, S_JUMP, S_ILLEGAL: state_n = S_FETCH;
      default:     state_n = S_FETCH;
    endcase
    start = (state_n != state_q) &&
            ((state_n == S_FETCH) || (state_n == S_MEM_READ) || (state_n == S_MEM_WRITE));
    out_n = state_outputs(state_n, funct_alu_op(funct));
  end

  assign i_or_d        = out_q.i_or_d;
  assign ir_write      = out_q.ir_write;
  assign pc_write      = out_q.pc_write;
  assign pc_write_cond = out_q.pc_write_cond;
  assign mem_write     = out_q.mem_write;
  assign reg_write     = out_q.reg_write;
  assign epc_write     = out_q.epc_write;
  assign pc_source     = out_q.pc_source;
  assign alu_src_a     = out_q.alu_src_a;
  assign alu_src_b     = out_q.alu_src_b;
  assign alu_op        = out_q.alu_op;
  assign reg_dst       = out_q.reg_dst;
  assign mem_to_reg    = out_q.mem_to_reg;
  assign state         = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: three instances (MEM_WAIT = 1, 2, 3) share one
// instruction stream and are checked every cycle against a cycle-position model.
module tb_multicycle_ctrl;

  logic       clock;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  int         phase;

  logic [1:0] iod   [3];
  logic       irw   [3];
  logic       pcw   [3];
  logic       pcwc  [3];
  logic       memw  [3];
  logic       regw  [3];
  logic       epcw  [3];
  logic [2:0] pcsrc [3];
  logic       srca  [3];
  logic [2:0] srcb  [3];
  logic [3:0] aluop [3];
  logic       rdst  [3];
  logic       m2r   [3];
  logic [6:0] st    [3];

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         m_phase = 0;
  logic [5:0] m_op = '0;
  logic [5:0] m_fn = '0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_ctrl #(.MEM_WAIT(g + 1), .STATE_W(7)) dut (
      .clock         (clock),
      .reset         (reset),
      .opcode        (opcode),
      .funct         (funct),
      .i_or_d        (iod[g]),
      .ir_write      (irw[g]),
      .pc_write      (pcw[g]),
      .pc_write_cond (pcwc[g]),
      .mem_write     (memw[g]),
      .reg_write     (regw[g]),
      .epc_write     (epcw[g]),
      .pc_source     (pcsrc[g]),
      .alu_src_a     (srca[g]),
      .alu_src_b     (srcb[g]),
      .alu_op        (aluop[g]),
      .reg_dst       (rdst[g]),
      .mem_to_reg    (m2r[g]),
      .state         (st[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit r_legal(input logic [5:0] fn);
    return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) || (fn == 6'h2A);
  endfunction

  // Expected state k cycles after reset, from instruction lengths and paths.
  function automatic logic [6:0] exp_state(input int w, input logic [5:0] op,
                                           input logic [5:0] fn, input int k);
    int len;
    int j;
    bit is_r;
    is_r = (op == 6'h00) && r_legal(fn);
    if (is_r || op == 6'h08) len = 4 + w;
    else if (op == 6'h23)    len = 4 + 2 * w;
    else if (op == 6'h2B)    len = 3 + 2 * w;
    else                     len = 3 + w;
    k = k % len;
    if (k < w)      return 7'h01;
    if (k == w)     return 7'h02;
    if (k == w + 1) return 7'h03;
    j = k - w - 2;
    if (is_r)         return (j == 0) ? 7'h04 : 7'h05;
    if (op == 6'h08)  return (j == 0) ? 7'h06 : 7'h07;
    if (op == 6'h23)  return (j == 0) ? 7'h08 : ((j <= w) ? 7'h09 : 7'h0A);
    if (op == 6'h2B)  return (j == 0) ? 7'h08 : 7'h0B;
    if (op == 6'h04)  return 7'h0C;
    if (op == 6'h02)  return 7'h0D;
    return 7'h0E;
  endfunction

  // Output vector {i_or_d, ir_w, pc_w, pc_wc, mem_w, reg_w, epc_w, pc_src, src_a, src_b, alu_op, reg_dst, m2r}.
  function automatic logic [20:0] exp_out(input logic [6:0] s, input logic [5:0] fn);
    logic [1:0] io; logic ir, pw, pwc, mw, rw, ew; logic [2:0] ps; logic sa;
    logic [2:0] sb; logic [3:0] ao; logic rd, mr;
    {io, ir, pw, pwc, mw, rw, ew, ps, sa, sb, ao, rd, mr} = '0;
    case (s)
      7'h01: begin sb = 3'd1; ao = 4'd1; end
      7'h02: begin ir = 1; pw = 1; sb = 3'd1; ao = 4'd1; end
      7'h03: begin sb = 3'd3; ao = 4'd1; end
      7'h04: begin
        sa = 1;
        case (fn)
          6'h20: ao = 4'd1; 6'h22: ao = 4'd2; 6'h24: ao = 4'd3;
          6'h25: ao = 4'd4; 6'h2A: ao = 4'd5; default: ao = 4'd0;
        endcase
      end
      7'h05: begin rw = 1; rd = 1; end
      7'h06, 7'h08: begin sa = 1; sb = 3'd2; ao = 4'd1; end
      7'h07: rw = 1;
      7'h09: io = 2'd1;
      7'h0A: begin rw = 1; mr = 1; end
      7'h0B: begin io = 2'd1; mw = 1; end
      7'h0C: begin sa = 1; ao = 4'd2; pwc = 1; ps = 3'd1; end
      7'h0D: begin pw = 1; ps = 3'd2; end
      7'h0E: begin ew = 1; pw = 1; ps = 3'd3; end
      default: ;
    endcase
    return {io, ir, pw, pwc, mw, rw, ew, ps, sa, sb, ao, rd, mr};
  endfunction

  function automatic logic [20:0] got_out(input int i);
    return {iod[i], irw[i], pcw[i], pcwc[i], memw[i], regw[i], epcw[i],
            pcsrc[i], srca[i], srcb[i], aluop[i], rdst[i], m2r[i]};
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s phase=%0d w=%0d cyc=%0d got=%h exp=%h", name, m_phase, inst + 1, cyc, got, exp);
    end
  endtask

  // Model position: reset edge is cycle 0; the instruction is latched with it.
  always @(posedge clock) begin
    if (reset) begin
      cyc     <= 0;
      m_op    <= opcode;
      m_fn    <= funct;
      m_phase <= phase;
    end else begin
      cyc <= cyc + 1;
    end
  end

  always @(negedge clock) begin
    logic [6:0] es;
    if (m_phase != 0) begin
      for (int i = 0; i < 3; i++) begin
        es = exp_state(i + 1, m_op, m_fn, cyc);
        chk("state", i, 32'(st[i]), 32'(es));
        chk("outputs", i, 32'(got_out(i)), 32'(exp_out(es, m_fn)));
      end
      case (m_phase)
        1: case (cyc)
          0: begin chk("sub_fetch", 0, 32'(st[0]), 32'h01); chk("sub_irw0", 0, 32'(irw[0]), 32'h0); end
          1: begin chk("sub_fwb", 0, 32'(st[0]), 32'h02); chk("sub_irw", 0, 32'(irw[0]), 32'h1);
                   chk("sub_pcw", 0, 32'(pcw[0]), 32'h1); end
          2: begin chk("sub_dec", 0, 32'(st[0]), 32'h03); chk("sub_irw2", 0, 32'(irw[0]), 32'h0); end
          3: begin chk("sub_exec", 0, 32'(st[0]), 32'h04); chk("sub_aluop", 0, 32'(aluop[0]), 32'h2); end
          4: begin chk("sub_wb", 0, 32'(st[0]), 32'h05); chk("sub_regw", 0, 32'(regw[0]), 32'h1);
                   chk("sub_rdst", 0, 32'(rdst[0]), 32'h1); end
          5: chk("sub_next", 0, 32'(st[0]), 32'h01);
          default: ;
        endcase
        2: case (cyc)
          2:  chk("lw_fetch_held", 2, 32'(st[2]), 32'h01);
          3:  chk("lw_fwb", 2, 32'(st[2]), 32'h02);
          8:  chk("lw_read_held", 2, 32'(st[2]), 32'h09);
          9:  begin chk("lw_wb", 2, 32'(st[2]), 32'h0A); chk("lw_m2r", 2, 32'(m2r[2]), 32'h1); end
          10: chk("lw_next", 2, 32'(st[2]), 32'h01);
          default: ;
        endcase
        3: case (cyc)
          5: begin chk("sw_st", 1, 32'(st[1]), 32'h0B); chk("sw_memw", 1, 32'(memw[1]), 32'h1);
                   chk("sw_iord", 1, 32'(iod[1]), 32'h1); end
          6: chk("sw_memw2", 1, 32'(memw[1]), 32'h1);
          7: begin chk("sw_next", 1, 32'(st[1]), 32'h01); chk("sw_memw_off", 1, 32'(memw[1]), 32'h0); end
          default: ;
        endcase
        4: case (cyc)
          3: begin chk("beq_st", 0, 32'(st[0]), 32'h0C); chk("beq_pcwc", 0, 32'(pcwc[0]), 32'h1);
                   chk("beq_pcsrc", 0, 32'(pcsrc[0]), 32'h1); end
          4: begin chk("beq_next", 0, 32'(st[0]), 32'h01); chk("beq_pcwc_off", 0, 32'(pcwc[0]), 32'h0); end
          default: ;
        endcase
        5: if (cyc == 3) begin
          chk("ill_st", 0, 32'(st[0]), 32'h0E);
          chk("ill_epcw", 0, 32'(epcw[0]), 32'h1);
          chk("ill_pcsrc", 0, 32'(pcsrc[0]), 32'h3);
        end
        11: case (cyc)
          0: begin chk("rst_fetch", 2, 32'(st[2]), 32'h01); chk("rst_memw", 2, 32'(memw[2]), 32'h0); end
          3: chk("rst_counter_restart", 2, 32'(st[2]), 32'h02);
          7: begin chk("pre_rst_st", 2, 32'(st[2]), 32'h0B); chk("pre_rst_memw", 2, 32'(memw[2]), 32'h1); end
          default: ;
        endcase
        default: ;
      endcase
    end
  end

  task automatic run(input int ph, input logic [5:0] op, input logic [5:0] fn, input int n);
    @(posedge clock);
    #1;
    reset  = 1'b1;
    opcode = op;
    funct  = fn;
    phase  = ph;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (n) @(posedge clock);
  endtask

  initial begin
    reset  = 1'b1;
    opcode = '0;
    funct  = '0;
    phase  = 0;
    run(1,  6'h00, 6'h22, 20);
    run(2,  6'h23, 6'h00, 24);
    run(3,  6'h2B, 6'h00, 20);
    run(4,  6'h04, 6'h00, 14);
    run(5,  6'h3F, 6'h00, 14);
    run(10, 6'h08, 6'h00, 16);
    run(10, 6'h02, 6'h00, 14);
    run(10, 6'h00, 6'h20, 16);
    run(10, 6'h00, 6'h24, 16);
    run(10, 6'h00, 6'h25, 16);
    run(10, 6'h00, 6'h2A, 16);
    run(10, 6'h00, 6'h3F, 14);
    // Reset lands while the MEM_WAIT=3 instance is inside MEM_WRITE.
    run(11, 6'h2B, 6'h00, 7);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (15) @(posedge clock);
    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised Moore control unit for the multicycle MIPS datapath. Runs the full instruction sequence (fetch with configurable memory wait states, decode, execute, memory, write-back) for R-type, addi, lw, sw, beq and j. It also traps illegal opcodes and functs to an exception vector. Sits beside the datapath and drives every mux select and write enable from its state register.

## Interface
- MEM_WAIT, 1: cycles each memory access state is held (≥1).
- STATE_W, 7: width of the state output.
- clock  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high; clock clock.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- i_or_d  out  2  memory address select: 00 = PC, 01 = ALUOut.
- ir_write, pc_write, pc_write_cond, mem_write, reg_write, epc_write  out  1 each  write enables.
- pc_source  out  3  000 = ALU result, 001 = ALUOut, 010 = jump target, 011 = exception vector 0x0000_0080.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  3  000 = register B, 001 = constant 4, 010 = sign-extended imm, 011 = sign-extended imm<<2.
- alu_op  out  4  0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 SLT.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- state  out  STATE_W  current state code.

## Operation
- Outputs are a pure function of the registered state (Moore). Every output not listed for a state is 0.
- Reset: while reset is high, state = FETCH at the next edge and the wait counter clears. Reset has priority over any transition, including mid-instruction.
- Outputs in FETCH (the reset state): i_or_d = 00, alu_src_a = 0, alu_src_b = 001, alu_op = ADD. All enables are 0.
- FETCH (01): as above; held MEM_WAIT cycles, then → FETCH_WB.
- FETCH_WB (02): ir_write = 1, pc_write = 1, pc_source = 000, alu_src_b = 001, alu_op = ADD → DECODE.
- DECODE (03): alu_src_a = 0, alu_src_b = 011, alu_op = ADD (branch target into ALUOut). Next state by opcode:
  - 0x00 with legal funct → EXEC_R.
  - 0x08 → EXEC_I.
  - 0x23 / 0x2B → MEM_ADDR.
  - 0x04 → BRANCH.
  - 0x02 → JUMP.
  - else → ILLEGAL.
- EXEC_R (04): alu_src_a = 1, alu_src_b = 000, alu_op from funct (0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT); → R_WB. Any other funct routes DECODE → ILLEGAL.
- R_WB (05): reg_write = 1, reg_dst = 1, mem_to_reg = 0 → FETCH.
- EXEC_I (06): alu_src_a = 1, alu_src_b = 010, ADD → I_WB.
- I_WB (07): reg_write = 1, reg_dst = 0, mem_to_reg = 0 → FETCH.
- MEM_ADDR (08): alu_src_a = 1, alu_src_b = 010, ADD. Next state: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ (09): i_or_d = 01; held MEM_WAIT cycles → LOAD_WB.
- LOAD_WB (0A): reg_write = 1, reg_dst = 0, mem_to_reg = 1 → FETCH.
- MEM_WRITE (0B): i_or_d = 01, mem_write = 1 for all MEM_WAIT cycles → FETCH.
- BRANCH (0C): alu_src_a = 1, alu_src_b = 000, SUB, pc_write_cond = 1, pc_source = 001 → FETCH.
- JUMP (0D): pc_write = 1, pc_source = 010 → FETCH.
- ILLEGAL (0E): epc_write = 1, pc_write = 1, pc_source = 011 → FETCH.
- Any undefined state code → FETCH on the next edge.

## Timing
- Wait counter: width $clog2(MEM_WAIT+1). It loads 0 on entry to FETCH, MEM_READ or MEM_WRITE and increments each cycle. The state exits when counter == MEM_WAIT-1. With MEM_WAIT = 1 the counter never blocks.
- Cycles per instruction, with W = MEM_WAIT:
  - R-type and addi: 4+W.
  - lw: 4+2W.
  - sw: 3+2W.
  - beq, j, illegal: 3+W.
- opcode and funct are sampled only in DECODE, one cycle after ir_write.
- Reset asserted in any cycle: state == FETCH and all enables are 0 in the cycle after the edge. No partial write enable ever persists past reset.

## Structure
- Shared package ctrl_pkg holds:
  - state codes;
  - alu_op, alu_src_b, pc_source and i_or_d encodings;
  - opcode and funct constants;
  - the exception vector.
- One natural sub-module, mem_wait_counter: parametrised on MEM_WAIT, with start and done signals. It is reused by the FETCH, MEM_READ and MEM_WRITE states.

## Test plan
- Reset then release, MEM_WAIT = 1 → state sequence 01, 02, 03. ir_write and pc_write are high only in 02.
- opcode 0x00, funct 0x22 → states 03→04→05; alu_op = 0010 in 04; reg_write = 1, reg_dst = 1 in 05; 5 cycles total.
- MEM_WAIT = 3, opcode 0x23 → FETCH held 3 cycles, MEM_READ held 3 cycles, mem_to_reg = 1 in LOAD_WB; 10 cycles total.
- opcode 0x2B, MEM_WAIT = 2 → mem_write high exactly 2 cycles with i_or_d = 01; next state FETCH.
- opcode 0x04 → pc_write_cond = 1, pc_source = 001 for 1 cycle. opcode 0x3F → ILLEGAL, epc_write = 1, pc_source = 011.
- reset raised during MEM_WRITE at MEM_WAIT = 3 → mem_write = 0 and state = 01 on the next cycle; the counter restarts on release.
